mult_div_unit: RTL and testbench



---
 rtl/multdiv_pkg.sv | 24 ++
 rtl/multdiv_step.sv | 41 ++++
 rtl/mult_div_unit.sv | 198 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding,
// FSM states, iteration count and a two's-complement helper.
package multdiv_pkg;

   localparam int DATA_W          = 32;
   localparam int ITER            = DATA_W;
   localparam int ITER_W          = $clog2(ITER);

   localparam logic OP_MULT       = 1'b0;
   localparam logic OP_DIV        = 1'b1;
   localparam int   OP_UNSIGNED_BIT = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic logic [DATA_W-1:0] twos_neg(input logic [DATA_W-1:0] v);
      return (~v) + {{(DATA_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/multdiv_step.sv
// One iteration of the datapath: a shift-add multiply step or a restoring
// divide step on the {hi,lo} working pair, selected by i_div.
module multdiv_step
   import multdiv_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic             i_div,
   input  logic [WIDTH-1:0] i_hi,
   input  logic [WIDTH-1:0] i_lo,
   input  logic [WIDTH-1:0] i_opnd,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_rem_sh;
   logic [WIDTH:0] w_diff;

   // Multiply adds into the upper half then shifts right; divide shifts left and trial-subtracts.
   always_comb begin
      w_sum    = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});
      w_rem_sh = {i_hi, i_lo[WIDTH-1]};
      w_diff   = w_rem_sh - {1'b0, i_opnd};
      o_hi     = i_hi;
      o_lo     = i_lo;
      if (i_div == OP_DIV) begin
         if (w_diff[WIDTH] == 1'b0) begin
            o_hi = w_diff[WIDTH-1:0];
            o_lo = {i_lo[WIDTH-2:0], 1'b1};
         end else begin
            o_hi = w_rem_sh[WIDTH-1:0];
            o_lo = {i_lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         o_hi = w_sum[WIDTH:1];
         o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential 32-bit multiply/divide unit producing HI/LO, one bit per cycle
// on operand magnitudes with a final sign fix. Macro MULTDIV_UNSIGNED_EN enables op[1] (multu/divu).
module mult_div_unit
   import multdiv_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [ITER_W-1:0]  r_cnt;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [WIDTH-1:0]   r_opnd;
   logic               r_op_div;
   logic               r_neg_res;
   logic               r_neg_rem;
   logic               r_div_zero;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_hi_out;
   logic [WIDTH-1:0]   r_lo_out;

   logic               w_unsigned;
   logic               w_is_div;
   logic               w_a_neg;
   logic               w_b_neg;
   logic               w_div_by_zero;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH-1:0]   w_step_hi;
   logic [WIDTH-1:0]   w_step_lo;
   logic [2*WIDTH-1:0] w_prod_neg;
   logic [WIDTH-1:0]   w_fix_hi;
   logic [WIDTH-1:0]   w_fix_lo;

`ifdef MULTDIV_UNSIGNED_EN
   assign w_unsigned = op[OP_UNSIGNED_BIT];
`else
   logic w_unused_op;
   assign w_unused_op = op[OP_UNSIGNED_BIT];
   assign w_unsigned  = 1'b0;
`endif

   assign w_is_div      = (op[0] == OP_DIV);
   assign w_a_neg       = ~w_unsigned & a[WIDTH-1];
   assign w_b_neg       = ~w_unsigned & b[WIDTH-1];
   assign w_a_mag       = w_a_neg ? twos_neg(a) : a;
   assign w_b_mag       = w_b_neg ? twos_neg(b) : b;
   assign w_div_by_zero = w_is_div & (b == {WIDTH{1'b0}});

   multdiv_step #(.WIDTH(WIDTH)) u_step (
      .i_div  (r_op_div),
      .i_hi   (r_hi),
      .i_lo   (r_lo),
      .i_opnd (r_opnd),
      .o_hi   (w_step_hi),
      .o_lo   (w_step_lo)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; a zero divisor skips straight to DONE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = w_div_by_zero ? DONE : RUN;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         RUN: begin
            if (r_cnt == {ITER_W{1'b0}}) begin
               w_state_nxt = FIX;
            end else begin
               w_state_nxt = RUN;
            end
         end
         FIX:     w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Sign correction of the finished magnitude result.
   assign w_prod_neg = (~{r_hi, r_lo}) + {{(2*WIDTH-1){1'b0}}, 1'b1};

   always_comb begin
      w_fix_hi = r_hi;
      w_fix_lo = r_lo;
      if (r_op_div) begin
         if (r_neg_res) begin
            w_fix_lo = twos_neg(r_lo);
         end else begin
            w_fix_lo = r_lo;
         end
         if (r_neg_rem) begin
            w_fix_hi = twos_neg(r_hi);
         end else begin
            w_fix_hi = r_hi;
         end
      end else if (r_neg_res) begin
         w_fix_hi = w_prod_neg[2*WIDTH-1:WIDTH];
         w_fix_lo = w_prod_neg[WIDTH-1:0];
      end else begin
         w_fix_hi = r_hi;
         w_fix_lo = r_lo;
      end
   end

   // Working registers: operand capture on accept, one iteration per RUN cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt      <= {ITER_W{1'b0}};
         r_hi       <= {WIDTH{1'b0}};
         r_lo       <= {WIDTH{1'b0}};
         r_opnd     <= {WIDTH{1'b0}};
         r_op_div   <= 1'b0;
         r_neg_res  <= 1'b0;
         r_neg_rem  <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_cnt      <= ITER_W'(ITER - 1);
                  r_hi       <= {WIDTH{1'b0}};
                  r_op_div   <= w_is_div;
                  r_neg_res  <= w_a_neg ^ w_b_neg;
                  r_neg_rem  <= w_a_neg;
                  r_div_zero <= w_div_by_zero;
                  // Divide shifts the dividend out of lo; multiply shifts the multiplier out.
                  if (w_is_div) begin
                     r_lo   <= w_a_mag;
                     r_opnd <= w_b_mag;
                  end else begin
                     r_lo   <= w_b_mag;
                     r_opnd <= w_a_mag;
                  end
               end
            end
            RUN: begin
               r_hi  <= w_step_hi;
               r_lo  <= w_step_lo;
               r_cnt <= r_cnt - {{(ITER_W-1){1'b0}}, 1'b1};
            end
            default: begin
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

   // Registered outputs; HI/LO load only on the FIX to DONE edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_hi_out <= {WIDTH{1'b0}};
         r_lo_out <= {WIDTH{1'b0}};
      end else begin
         r_busy <= (w_state_nxt != IDLE);
         r_done <= (w_state_nxt == DONE);
         if (r_state == FIX) begin
            r_hi_out <= w_fix_hi;
            r_lo_out <= w_fix_lo;
         end
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign div_zero = r_div_zero;
   assign hi_out   = r_hi_out;
   assign lo_out   = r_lo_out;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: expected HI/LO pushed to a scoreboard
// queue at issue time and popped when done is observed.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = 32'h0;
   logic [31:0] b = 32'h0;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          lat;
   } exp_t;

   exp_t exp_q[$];

   logic [31:0] m_hi;
   logic [31:0] m_lo;
   logic        m_dz;
   logic        m_timeout;
   logic        m_extra_done;
   int          m_lat;
   int          m_busy;

   mult_div_unit dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi_out   (hi_out),
      .lo_out   (lo_out)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic push_exp(input logic [31:0] h, input logic [31:0] l, input logic dz, input int lat);
      exp_t e;
      e.hi = h; e.lo = l; e.dz = dz; e.lat = lat;
      exp_q.push_back(e);
   endtask

   // Issue one op just after a clock edge and measure it up to one cycle past done.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
      m_lat  = 1;
      m_busy = (busy === 1'b1) ? 1 : 0;
      while (done !== 1'b1 && m_lat < 60) begin
         @(posedge clk); #1;
         m_lat++;
         if (busy === 1'b1) m_busy++;
      end
      m_timeout = (done !== 1'b1);
      m_hi = hi_out; m_lo = lo_out; m_dz = div_zero;
      @(posedge clk); #1;
      m_extra_done = done;
   endtask

   task automatic test_reset;
      #12;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
      total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz: got %b want 0", div_zero); end
      total++; if (hi_out !== 32'h0) begin bad++; $display("FAIL reset_hi: got %h want 0", hi_out); end
      total++; if (lo_out !== 32'h0) begin bad++; $display("FAIL reset_lo: got %h want 0", lo_out); end
      #10 reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_mult;
      logic [31:0] ta [3] = '{32'h7, 32'h7FFFFFFF, 32'hFFFF0000};
      logic [31:0] tb [3] = '{32'hFFFFFFFD, 32'h7FFFFFFF, 32'hFFFF0000};
      logic [31:0] th [3] = '{32'hFFFFFFFF, 32'h3FFFFFFF, 32'h00000001};
      logic [31:0] tl [3] = '{32'hFFFFFFEB, 32'h00000001, 32'h00000000};
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         push_exp(th[i], tl[i], 1'b0, 34);
         run_op(2'b00, ta[i], tb[i]);
         e = exp_q.pop_front();
         total++; if (m_timeout !== 1'b0) begin bad++; $display("FAIL mult_timeout[%0d]: no done", i); end
         total++; if (m_hi !== e.hi) begin bad++; $display("FAIL mult_hi[%0d]: got %h want %h", i, m_hi, e.hi); end
         total++; if (m_lo !== e.lo) begin bad++; $display("FAIL mult_lo[%0d]: got %h want %h", i, m_lo, e.lo); end
         total++; if (m_lat != e.lat) begin bad++; $display("FAIL mult_latency[%0d]: got %0d want %0d", i, m_lat, e.lat); end
         total++; if (m_busy != 34) begin bad++; $display("FAIL mult_busy_cycles[%0d]: got %0d want 34", i, m_busy); end
         total++; if (m_extra_done !== 1'b0) begin bad++; $display("FAIL mult_done_pulse[%0d]: done still %b", i, m_extra_done); end
      end
   endtask

   task automatic test_div;
      logic [31:0] ta [5] = '{32'hFFFFFFF9, 32'h80000000, 32'd100, 32'hFFFFFF9C, 32'd7};
      logic [31:0] tb [5] = '{32'd2, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFF9, 32'd100};
      logic [31:0] th [5] = '{32'hFFFFFFFF, 32'h0, 32'd2, 32'hFFFFFFFE, 32'd7};
      logic [31:0] tl [5] = '{32'hFFFFFFFD, 32'h80000000, 32'd14, 32'd14, 32'd0};
      exp_t e;
      for (int i = 0; i < 5; i++) begin
         push_exp(th[i], tl[i], 1'b0, 34);
         run_op(2'b01, ta[i], tb[i]);
         e = exp_q.pop_front();
         total++; if (m_timeout !== 1'b0) begin bad++; $display("FAIL div_timeout[%0d]: no done", i); end
         total++; if (m_hi !== e.hi) begin bad++; $display("FAIL div_hi[%0d]: got %h want %h", i, m_hi, e.hi); end
         total++; if (m_lo !== e.lo) begin bad++; $display("FAIL div_lo[%0d]: got %h want %h", i, m_lo, e.lo); end
         total++; if (m_dz !== e.dz) begin bad++; $display("FAIL div_dz[%0d]: got %b want %b", i, m_dz, e.dz); end
         total++; if (m_lat != e.lat) begin bad++; $display("FAIL div_latency[%0d]: got %0d want %0d", i, m_lat, e.lat); end
      end
   endtask

   task automatic test_div_zero;
      exp_t e;
      push_exp(32'h11, 32'h22, 1'b0, 34);
      run_op(2'b01, 32'h451, 32'h20);
      e = exp_q.pop_front();
      total++; if ({m_hi, m_lo} !== {e.hi, e.lo}) begin bad++; $display("FAIL dz_preload: got %h/%h want %h/%h", m_hi, m_lo, e.hi, e.lo); end
      push_exp(32'h11, 32'h22, 1'b1, 1);
      run_op(2'b01, 32'd5, 32'd0);
      e = exp_q.pop_front();
      total++; if (m_lat != e.lat) begin bad++; $display("FAIL dz_latency: got %0d want %0d", m_lat, e.lat); end
      total++; if (m_busy != 1) begin bad++; $display("FAIL dz_busy_cycles: got %0d want 1", m_busy); end
      total++; if (m_dz !== e.dz) begin bad++; $display("FAIL dz_flag: got %b want %b", m_dz, e.dz); end
      total++; if (m_hi !== e.hi) begin bad++; $display("FAIL dz_hi_held: got %h want %h", m_hi, e.hi); end
      total++; if (m_lo !== e.lo) begin bad++; $display("FAIL dz_lo_held: got %h want %h", m_lo, e.lo); end
      total++; if (m_extra_done !== 1'b0) begin bad++; $display("FAIL dz_done_pulse: done still %b", m_extra_done); end
      push_exp(32'h0, 32'd6, 1'b0, 34);
      run_op(2'b00, 32'd2, 32'd3);
      e = exp_q.pop_front();
      total++; if (m_dz !== e.dz) begin bad++; $display("FAIL dz_cleared: got %b want %b", m_dz, e.dz); end
      total++; if (m_lo !== e.lo) begin bad++; $display("FAIL dz_next_lo: got %h want %h", m_lo, e.lo); end
   endtask

   task automatic test_unsigned;
      logic [1:0]  to [3] = '{2'b11, 2'b11, 2'b10};
      logic [31:0] ta [3] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
      logic [31:0] tb [3] = '{32'd2, 32'hFFFFFFFF, 32'd2};
`ifdef MULTDIV_UNSIGNED_EN
      logic [31:0] th [3] = '{32'h1, 32'h80000000, 32'h1};
      logic [31:0] tl [3] = '{32'h7FFFFFFF, 32'h0, 32'hFFFFFFFE};
`else
      logic [31:0] th [3] = '{32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF};
      logic [31:0] tl [3] = '{32'h0, 32'h80000000, 32'hFFFFFFFE};
`endif
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         push_exp(th[i], tl[i], 1'b0, 34);
         run_op(to[i], ta[i], tb[i]);
         e = exp_q.pop_front();
         total++; if (m_hi !== e.hi) begin bad++; $display("FAIL uns_hi[%0d]: got %h want %h", i, m_hi, e.hi); end
         total++; if (m_lo !== e.lo) begin bad++; $display("FAIL uns_lo[%0d]: got %h want %h", i, m_lo, e.lo); end
      end
   endtask

   task automatic test_random;
      exp_t        e;
      logic [31:0] x;
      logic [31:0] y;
      longint      sx;
      longint      sy;
      longint      r64;
      logic [63:0] p;
      for (int i = 0; i < 12; i++) begin
         x = $urandom;
         y = ((i % 4) == 3) ? 32'($urandom_range(1, 20)) : $urandom;
         if (y == 32'h0) y = 32'h1;
         sx = longint'($signed(x));
         sy = longint'($signed(y));
         if ((i % 2) == 0) begin
            r64 = sx * sy;
            p = r64;
            push_exp(p[63:32], p[31:0], 1'b0, 34);
         end else begin
            r64 = sx / sy;
            p = r64;
            x = p[31:0];
            r64 = sx % sy;
            p = r64;
            push_exp(p[31:0], x, 1'b0, 34);
            x = 32'(sx);
         end
         run_op({1'b0, 1'(i % 2)}, x, y);
         e = exp_q.pop_front();
         total++; if ({m_hi, m_lo} !== {e.hi, e.lo}) begin bad++; $display("FAIL rand[%0d] op%0d a=%h b=%h: got %h/%h want %h/%h", i, i % 2, x, y, m_hi, m_lo, e.hi, e.lo); end
      end
   endtask

   task automatic test_back_to_back;
      exp_t e;
      int   lat;
      push_exp(32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34);
      start = 1'b1; op = 2'b00; a = 32'd7; b = 32'hFFFFFFFD;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      repeat (4) begin @(posedge clk); #1; lat++; end
      start = 1'b1; a = 32'd2; b = 32'd2;
      @(posedge clk); #1;
      lat++;
      start = 1'b0;
      while (done !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
      e = exp_q.pop_front();
      total++; if (lat != e.lat) begin bad++; $display("FAIL b2b_latency: got %0d want %0d", lat, e.lat); end
      total++; if ({hi_out, lo_out} !== {e.hi, e.lo}) begin bad++; $display("FAIL b2b_result: got %h/%h want %h/%h", hi_out, lo_out, e.hi, e.lo); end
      // start raised in the DONE cycle must wait for the following IDLE cycle
      push_exp(32'h0, 32'd12, 1'b0, 34);
      start = 1'b1; a = 32'd3; b = 32'd4;
      @(posedge clk); #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_done_start_ignored: busy %b want 0", busy); end
      @(posedge clk); #1;
      start = 1'b0;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_idle_start_accepted: busy %b want 1", busy); end
      lat = 1;
      while (done !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
      e = exp_q.pop_front();
      total++; if (lat != e.lat) begin bad++; $display("FAIL b2b2_latency: got %0d want %0d", lat, e.lat); end
      total++; if ({hi_out, lo_out} !== {e.hi, e.lo}) begin bad++; $display("FAIL b2b2_result: got %h/%h want %h/%h", hi_out, lo_out, e.hi, e.lo); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_abort;
      int dones;
      start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      reset_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done: got %b want 0", done); end
      total++; if (hi_out !== 32'h0) begin bad++; $display("FAIL abort_hi: got %h want 0", hi_out); end
      total++; if (lo_out !== 32'h0) begin bad++; $display("FAIL abort_lo: got %h want 0", lo_out); end
      #2 reset_n = 1'b1;
      dones = 0;
      repeat (50) begin
         @(posedge clk); #1;
         if (done === 1'b1) dones++;
      end
      total++; if (dones != 0) begin bad++; $display("FAIL abort_no_done: got %0d dones want 0", dones); end
      total++; if (lo_out !== 32'h0) begin bad++; $display("FAIL abort_lo_unwritten: got %h want 0", lo_out); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_zero();
      test_unsigned();
      test_random();
      test_back_to_back();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
